cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Execution-rate controller between the free-running `clk` source and the processor core. Consumes `clk` and produces a single-cycle clock-enable `ce` that the core, register file and memories qualify every state update with. Supports continuous run at a programmable divided rate, single-step, external halt and an optional cycle-count breakpoint. Keeps a retired-enable counter for debug.

## Interface
- `DIV_W`, 8, width of the divide-ratio input
- `CNT_W`, 32, width of the enable/cycle counter and breakpoint compare

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 requests continuous execution
- `step`  in  1  one-clk pulse; requests exactly one enable
- `halt_req`  in  1  level; forces HALT from RUN/STEP
- `div`  in  DIV_W  enable period minus one (0 = every clk)
- `bp_en`  in  1  breakpoint compare enable
- `break_cycle`  in  CNT_W  breakpoint value for `cycle_count`
- `ce`  out  1  registered clock-enable to core, one clk wide
- `state`  out  2  IDLE=00, RUN=01, STEP=10, HALT=11
- `cycle_count`  out  CNT_W  number of `ce` pulses issued

## Operation
- Internal: prescaler `p` (DIV_W), latched divisor `div_q` (DIV_W).
- Reset (async, `rst_n`=0): state=IDLE, `ce`=0, `cycle_count`=0, `p`=0, `div_q`=0. All outputs held at these values while `rst_n`=0.
- IDLE:
  - `halt_req`=1 -> stay IDLE.
  - Else `run`=1 -> RUN.
  - Else `step`=1 -> STEP.
  - On any exit: `p`<=0, `div_q`<=`div`.
- RUN/STEP, per edge with `halt_req`=0:
  - If `p`==`div_q`: `ce`<=1, `cycle_count`<=`cycle_count`+1, `p`<=0, `div_q`<=`div`.
  - Else: `ce`<=0, `p`<=`p`+1.
- RUN: `run`=0 sampled -> IDLE, `ce`<=0, pending partial period discarded.
- STEP: after issuing its single `ce`, next state IDLE. `run` is ignored while in STEP.
- HALT: `ce`<=0, `p`<=0. Stays until `run`=0 and `halt_req`=0, then -> IDLE.
- `step` is ignored in every state except IDLE.
- `cycle_count` wraps from 2^CNT_W-1 to 0 with no flag. It is never cleared except by reset.

## Timing
- Entry into RUN/STEP at edge E: first `ce` is high in the cycle after edge E+`div_q`+1. In RUN, subsequent pulses follow every `div_q`+1 clks.
- `div`=0: `ce` is continuously high in RUN, from the cycle after E+1.
- `div` changes take effect only at a period boundary (reload of `div_q`). A period in progress is never stretched or cut.
- `halt_req` priority: on an edge where `halt_req`=1 in RUN/STEP, state<=HALT and `ce`<=0, even if `p`==`div_q`. No count increment.
- `run` drop and terminal count on the same edge: `ce`<=1 (the period completes), state<=IDLE.
- Latency from `halt_req` high (sampled at edge) to `ce` low: 0 cycles after that edge.

## Configuration
- `CPU_RUN_CTRL_BREAK_EN` defined:
  - On an edge issuing `ce` with `bp_en`=1 and `cycle_count`+1==`break_cycle`, the pulse is issued and the count updated.
  - State goes to HALT on that same edge; no further `ce`.
  - Breakpoint in STEP also goes to HALT, not IDLE.
- Not defined: no compare logic; `bp_en` and `break_cycle` remain ports but are ignored.

## Test plan
- Reset: `rst_n`=0 asynchronously mid-RUN with `div`=0 -> `ce`=0, `state`=00 and `cycle_count`=0 immediately, without waiting for an edge.
- Divided run: `div`=3, `run`=1 for 20 clks -> `ce` high exactly 1 of every 4 clks, first after E+4; `cycle_count`=5 after 20 clks.
- Single step: IDLE, `div`=2, one `step` pulse -> exactly one `ce` 3 clks later; `state` returns to 00; `cycle_count`+=1. A second `step` issued while in STEP is ignored.
- Halt collision: `div`=0 in RUN, assert `halt_req` -> `ce` low after that edge, `state`=11. `cycle_count` does not increment on that edge. Drop both `run` and `halt_req` -> IDLE.
- Divide change: `div` 1->4 mid-period -> current 2-clk period completes, then 5-clk periods follow.
- Breakpoint (`CPU_RUN_CTRL_BREAK_EN`): `bp_en`=1, `break_cycle`=10, `div`=0, run -> exactly 10 `ce` pulses, `cycle_count`=10, `state`=11. Without the macro: counting continues past 10.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Execution-rate controller: divided continuous run, single-step, halt and debug enable counter.
// Optional cycle-count breakpoint enabled by defining CPU_RUN_CTRL_BREAK_EN.
//
// state | meaning
// IDLE  | core frozen, waiting for run or step
// RUN   | continuous enables every div_q+1 clks
// STEP  | one enable after div_q+1 clks, then back to IDLE
// HALT  | forced stop; waits for run and halt_req both low
module cpu_run_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [DIV_W-1:0] div,
    input  logic             bp_en,
    input  logic [CNT_W-1:0] break_cycle,
    output logic             ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t             state_q, state_nxt;
    logic [DIV_W-1:0]   p, p_nxt;
    logic [DIV_W-1:0]   div_q, div_q_nxt;
    logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
    logic               ce_nxt;
    logic               tc;
    logic               idle_exit;
    logic               bp_hit;

    assign tc        = (p == div_q);
    assign idle_exit = !halt_req && (run || step);
    assign cnt_inc   = cycle_count + CNT_W'(1);
    assign state     = state_q;

`ifdef CPU_RUN_CTRL_BREAK_EN
    assign bp_hit = bp_en && (cnt_inc == break_cycle);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, break_cycle};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (idle_exit) state_nxt = run ? S_RUN : S_STEP;
            end
            S_RUN: begin
                if (halt_req)    state_nxt = S_HALT;
                else if (tc)     state_nxt = bp_hit ? S_HALT : (run ? S_RUN : S_IDLE);
                else if (!run)   state_nxt = S_IDLE;
            end
            S_STEP: begin
                if (halt_req)    state_nxt = S_HALT;
                else if (tc)     state_nxt = bp_hit ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                if (!run && !halt_req) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Halt wins over a terminal count on the same edge; a run drop does not.
    always_comb begin
        ce_nxt    = 1'b0;
        p_nxt     = p;
        div_q_nxt = div_q;
        cnt_nxt   = cycle_count;
        case (state_q)
            S_IDLE: begin
                if (idle_exit) begin
                    p_nxt     = '0;
                    div_q_nxt = div;
                end
            end
            S_RUN, S_STEP: begin
                if (halt_req) begin
                    p_nxt = '0;
                end else if (tc) begin
                    ce_nxt    = 1'b1;
                    cnt_nxt   = cnt_inc;
                    p_nxt     = '0;
                    div_q_nxt = div;
                end else if (state_q == S_RUN && !run) begin
                    p_nxt = '0;
                end else begin
                    p_nxt = p + DIV_W'(1);
                end
            end
            S_HALT: begin
                p_nxt = '0;
            end
            default: p_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce          <= 1'b0;
            p           <= '0;
            div_q       <= '0;
            cycle_count <= '0;
        end else begin
            ce          <= ce_nxt;
            p           <= p_nxt;
            div_q       <= div_q_nxt;
            cycle_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl; expectations are hand-computed per step.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step, halt_req, bp_en;
    logic [7:0]  div;
    logic [31:0] break_cycle;
    logic        ce;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;
    int pulses;

    cpu_run_ctrl #(.DIV_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
        .div(div), .bp_en(bp_en), .break_cycle(break_cycle),
        .ce(ce), .state(state), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 0; step = 0; halt_req = 0; bp_en = 0;
        div = 8'd0; break_cycle = 32'd0;
        tick(); tick();
        chk("reset_ce", {31'd0, ce}, 0);
        chk("reset_state", {30'd0, state}, 0);
        chk("reset_count", cycle_count, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", {30'd0, state}, 0);

        // Divided run, div=3: pulse on every 4th edge after entry
        div = 8'd3; run = 1;
        tick();
        chk("run_entry_state", {30'd0, state}, 1);
        chk("run_entry_ce", {31'd0, ce}, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("div3_ce_%0d", i), {31'd0, ce}, (i % 4 == 0) ? 1 : 0);
        end
        chk("div3_count", cycle_count, 5);
        run = 0;
        tick();
        chk("run_drop_state", {30'd0, state}, 0);
        chk("run_drop_ce", {31'd0, ce}, 0);
        chk("run_drop_count", cycle_count, 5);

        // Single step with div=2; second step pulse during STEP is ignored
        div = 8'd2; step = 1;
        tick();
        step = 0;
        chk("step_state", {30'd0, state}, 2);
        tick();
        step = 1;
        tick();
        step = 0;
        chk("step_mid_ce", {31'd0, ce}, 0);
        chk("step_mid_state", {30'd0, state}, 2);
        tick();
        chk("step_ce", {31'd0, ce}, 1);
        chk("step_ret_idle", {30'd0, state}, 0);
        chk("step_count", cycle_count, 6);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ce) pulses++;
        end
        chk("step_ignored_pulses", pulses, 0);
        chk("step_ignored_count", cycle_count, 6);

        // Halt collision at div=0
        div = 8'd0; run = 1;
        tick();
        tick();
        chk("div0_ce", {31'd0, ce}, 1);
        chk("div0_count1", cycle_count, 7);
        tick();
        chk("div0_count2", cycle_count, 8);
        halt_req = 1;
        tick();
        chk("halt_ce", {31'd0, ce}, 0);
        chk("halt_state", {30'd0, state}, 3);
        chk("halt_count", cycle_count, 8);
        tick();
        chk("halt_hold", {30'd0, state}, 3);
        run = 0; halt_req = 0;
        tick();
        chk("halt_exit_state", {30'd0, state}, 0);
        chk("halt_exit_count", cycle_count, 8);
        halt_req = 1; run = 1;
        tick();
        chk("idle_halt_block", {30'd0, state}, 0);
        halt_req = 0; run = 0;

        // Divide change 1 -> 4 mid-period
        div = 8'd1; run = 1;
        tick();
        tick();
        chk("dchg_e1_ce", {31'd0, ce}, 0);
        tick();
        chk("dchg_e2_ce", {31'd0, ce}, 1);
        chk("dchg_e2_count", cycle_count, 9);
        tick();
        chk("dchg_e3_ce", {31'd0, ce}, 0);
        div = 8'd4;
        tick();
        chk("dchg_e4_ce", {31'd0, ce}, 1);
        chk("dchg_e4_count", cycle_count, 10);
        for (int e = 5; e <= 14; e++) begin
            tick();
            chk($sformatf("dchg_ce_e%0d", e), {31'd0, ce}, (e == 9 || e == 14) ? 1 : 0);
        end
        chk("dchg_count", cycle_count, 12);
        run = 0;
        tick();
        chk("dchg_idle", {30'd0, state}, 0);

        // Asynchronous reset mid-RUN
        div = 8'd0; run = 1;
        tick(); tick(); tick();
        chk("pre_rst_ce", {31'd0, ce}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ce", {31'd0, ce}, 0);
        chk("async_rst_state", {30'd0, state}, 0);
        chk("async_rst_count", cycle_count, 0);
        run = 0;
        tick();
        rst_n = 1'b1;

        // Breakpoint at cycle 10, div=0
        bp_en = 1; break_cycle = 32'd10; run = 1;
        tick();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ce) pulses++;
        end
`ifdef CPU_RUN_CTRL_BREAK_EN
        chk("bp_pulses", pulses, 10);
        chk("bp_count", cycle_count, 10);
        chk("bp_state", {30'd0, state}, 3);
`else
        chk("nobp_pulses", pulses, 15);
        chk("nobp_count", cycle_count, 15);
        chk("nobp_state", {30'd0, state}, 1);
`endif
        run = 0; bp_en = 0;
        tick();
        chk("final_idle", {30'd0, state}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
